// File: rtl/dmux4_arbiter.sv
// dmux4_arbiter: round-robin arbiter that owns the select and one-hot grant
// of a shared DMux4Way fan-out. The grant is held until the owner drops its
// request, or until a hold timeout hands it to the next waiting requester.
// Optional feature: define ARB_LOCK_EN to add a lock_i input. While a grant
// is held with lock_i=1, the timeout is suppressed and the hold counter is
// frozen.
module dmux4_arbiter #(
    parameter int MAX_HOLD = 8,   // 0 disables the hold timeout
    parameter int CNT_W    = 4    // must satisfy 2**CNT_W > MAX_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_i,
`ifdef ARB_LOCK_EN
    input  logic       lock_i,
`endif
    output logic [3:0] gnt_o,
    output logic [1:0] sel_o,
    output logic       busy_o,
    output logic       preempt_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Last counter value before the timeout fires. The counter sits at 0
    // when the timeout is disabled.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t           state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       sel_q;
    logic [3:0]       gnt_q;
    logic             busy_q;
    logic             preempt_q;
    logic [CNT_W-1:0] cnt_q;

    logic             lock_w;
    logic [1:0]       ptr_d;        // priority pointer after the owner gives up
    logic [3:0]       others_d;     // requests excluding the current owner
    logic [2:0]       idle_pick_d;  // {found, index} scanning from ptr_q
    logic [2:0]       hand_pick_d;  // {found, index} scanning from ptr_d
    logic             owner_req_d;
    logic             timeout_d;

`ifdef ARB_LOCK_EN
    assign lock_w = lock_i;
`else
    assign lock_w = 1'b0;
`endif

    // Scan r from index p upward (mod 4); the first set bit wins.
    function automatic logic [2:0] arb_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Arbitration decisions for the current cycle, all based on sampled req_i.
    always_comb begin
        ptr_d       = sel_q + 2'd1;
        others_d    = req_i & ~gnt_q;
        idle_pick_d = arb_pick(req_i, ptr_q);
        hand_pick_d = arb_pick(others_d, ptr_d);
        owner_req_d = req_i[sel_q];
        timeout_d   = (MAX_HOLD != 0) && !lock_w && (cnt_q == HOLD_LAST) && (|others_d);
    end

    // Arbiter FSM with registered grant, select, busy and preempt outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (idle_pick_d[2]) begin
                        state_q <= GRANT;
                        sel_q   <= idle_pick_d[1:0];
                        gnt_q   <= onehot(idle_pick_d[1:0]);
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req_d) begin
                        // Owner released: hand off directly or fall back to idle.
                        ptr_q <= ptr_d;
                        cnt_q <= '0;
                        if (hand_pick_d[2]) begin
                            sel_q <= hand_pick_d[1:0];
                            gnt_q <= onehot(hand_pick_d[1:0]);
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= 4'b0000;
                            busy_q  <= 1'b0;
                        end
                    end else if (timeout_d) begin
                        // Owner held too long while others wait: rotate.
                        ptr_q     <= ptr_d;
                        cnt_q     <= '0;
                        sel_q     <= hand_pick_d[1:0];
                        gnt_q     <= onehot(hand_pick_d[1:0]);
                        preempt_q <= 1'b1;
                    end else if (!lock_w && (cnt_q != HOLD_LAST)) begin
                        // Counter saturates at HOLD_LAST so a late contender
                        // triggers rotation on its first sampled edge.
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign sel_o     = sel_q;
    assign busy_o    = busy_q;
    assign preempt_o = preempt_q;

endmodule
